// File: rtl/lif_pkg.sv
// Shared defaults, membrane type and saturating-add helper for the LIF neuron array.
package lif_pkg;

  localparam int LIF_WIDTH    = 8;
  localparam int LIF_BETA_W   = 3;
  localparam int LIF_REFRAC_W = 3;

  typedef logic [LIF_WIDTH-1:0] mem_t;

  // Adds two unsigned values and clips the result to w bits.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] s;
    logic [32:0] max;
    s   = {1'b0, a} + {1'b0, b};
    max = (33'd1 << w) - 33'd1;
    return (s > max) ? max[31:0] : s[31:0];
  endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational single-neuron LIF datapath: leak, integrate, saturate, threshold, refractory.
module lif_update
  import lif_pkg::*;
#(
  parameter int WIDTH    = LIF_WIDTH,
  parameter int BETA_W   = LIF_BETA_W,
  parameter int REFRAC_W = LIF_REFRAC_W
) (
  input  logic [WIDTH-1:0]    i_mem,
  input  logic [WIDTH-1:0]    i_cur,
  input  logic [WIDTH-1:0]    i_threshold,
  input  logic [BETA_W-1:0]   i_beta,
  input  logic [REFRAC_W-1:0] i_refrac_len,
  input  logic [REFRAC_W-1:0] i_cnt,
  output logic [WIDTH-1:0]    o_mem,
  output logic [REFRAC_W-1:0] o_cnt,
  output logic                o_spike
);

  logic [WIDTH-1:0] w_kept;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_thr;

  // beta = 0 shifts out nothing, so the whole membrane leaks away
  assign w_kept = i_mem - (i_mem >> i_beta);
  assign w_sum  = WIDTH'(sat_add(32'(w_kept), 32'(i_cur), WIDTH));
  assign w_thr  = (i_threshold == '0) ? WIDTH'(1) : i_threshold;

  always_comb begin
    o_mem   = w_sum;
    o_cnt   = i_cnt;
    o_spike = 1'b0;
    if (i_cnt != '0) begin
      o_mem = '0;
      o_cnt = i_cnt - REFRAC_W'(1);
    end else if (w_sum >= w_thr) begin
      o_spike = 1'b1;
      o_mem   = w_sum - w_thr;
      o_cnt   = i_refrac_len;
    end
  end

endmodule

// File: rtl/lif_array.sv
// Time-multiplexed LIF neuron array sharing one update datapath, round-robin scheduled.
// Refractory counters are built only when LIF_ARRAY_REFRAC_EN is defined.
module lif_array
  import lif_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int WIDTH     = LIF_WIDTH,
  parameter int BETA_W    = LIF_BETA_W,
  parameter int REFRAC_W  = LIF_REFRAC_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [N_NEURONS*WIDTH-1:0]   cur_in,
  input  logic [WIDTH-1:0]             threshold,
  input  logic [BETA_W-1:0]            beta,
  input  logic [REFRAC_W-1:0]          refrac_len,
  input  logic [$clog2(N_NEURONS)-1:0] sel,
  output logic [N_NEURONS-1:0]         spike,
  output logic [WIDTH-1:0]             state_out,
  output logic                         frame_done
);

  localparam int IDX_W = $clog2(N_NEURONS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  logic [IDX_W-1:0]    r_idx;
  logic [WIDTH-1:0]    r_mem [N_NEURONS];
  logic [N_NEURONS-1:0] r_spike;
  logic [WIDTH-1:0]    r_state;
  logic                r_frame_done;

  logic [WIDTH-1:0]    w_cur;
  logic [WIDTH-1:0]    w_mem_nxt;
  logic [REFRAC_W-1:0] w_cnt_cur;
  logic [REFRAC_W-1:0] w_cnt_nxt;
  logic                w_spike;

  assign w_cur = cur_in[r_idx*WIDTH +: WIDTH];

  lif_update #(
    .WIDTH   (WIDTH),
    .BETA_W  (BETA_W),
    .REFRAC_W(REFRAC_W)
  ) u_update (
    .i_mem       (r_mem[r_idx]),
    .i_cur       (w_cur),
    .i_threshold (threshold),
    .i_beta      (beta),
    .i_refrac_len(refrac_len),
    .i_cnt       (w_cnt_cur),
    .o_mem       (w_mem_nxt),
    .o_cnt       (w_cnt_nxt),
    .o_spike     (w_spike)
  );

`ifdef LIF_ARRAY_REFRAC_EN
  logic [REFRAC_W-1:0] r_cnt [N_NEURONS];

  assign w_cnt_cur = r_cnt[r_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) r_cnt[i] <= '0;
    end else if (en) begin
      r_cnt[r_idx] <= w_cnt_nxt;
    end
  end
`else
  // Counter permanently zero: the datapath never enters its refractory branch.
  logic w_unused_cnt;
  assign w_cnt_cur    = '0;
  assign w_unused_cnt = ^w_cnt_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= '0;
      r_spike      <= '0;
      r_state      <= '0;
      r_frame_done <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) r_mem[i] <= '0;
    end else begin
      // Reads the pre-update membrane when sel matches the neuron being written.
      r_state      <= r_mem[sel];
      r_frame_done <= en && (r_idx == LAST_IDX);
      if (en) begin
        r_mem[r_idx]   <= w_mem_nxt;
        r_spike[r_idx] <= w_spike;
        r_idx          <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
      end
    end
  end

  assign spike      = r_spike;
  assign state_out  = r_state;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_lif_array.sv
// Self-checking bench for lif_array: arithmetic reference model plus directed literal checks.
module tb_lif_array;

  localparam int N = 4;
  localparam int W = 8;
  localparam int MAXV = (1 << W) - 1;

  logic           clk;
  logic           rst_n;
  logic           en;
  logic [N*W-1:0] cur_in;
  logic [W-1:0]   threshold;
  logic [2:0]     beta;
  logic [2:0]     refrac_len;
  logic [1:0]     sel;
  logic [N-1:0]   spike;
  logic [W-1:0]   state_out;
  logic           frame_done;

  int n_checks = 0;
  int n_err    = 0;

  lif_array #(.N_NEURONS(N), .WIDTH(W), .BETA_W(3), .REFRAC_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cur_in    (cur_in),
    .threshold (threshold),
    .beta      (beta),
    .refrac_len(refrac_len),
    .sel       (sel),
    .spike     (spike),
    .state_out (state_out),
    .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    int mem;
    int cnt;
    bit spk;
  } upd_t;

  function automatic upd_t neuron_step(input int mem, input int cnt, input int cur,
                                       input int th, input int b, input int rl);
    upd_t r;
    int   sum;
    int   th_eff;
    th_eff = (th == 0) ? 1 : th;
    sum    = mem - (mem >> b) + cur;
    if (sum > MAXV) sum = MAXV;
`ifdef LIF_ARRAY_REFRAC_EN
    if (cnt != 0) begin
      r.mem = 0; r.cnt = cnt - 1; r.spk = 1'b0;
      return r;
    end
`endif
    if (sum >= th_eff) begin
      r.mem = sum - th_eff; r.cnt = rl; r.spk = 1'b1;
    end else begin
      r.mem = sum; r.cnt = cnt; r.spk = 1'b0;
    end
    return r;
  endfunction

  int         m_mem [N];
  int         m_cnt [N];
  logic [N-1:0] m_spike;
  int         m_idx;
  int         m_state;
  bit         m_fd;
  upd_t       m_nxt;

  always_comb m_nxt = neuron_step(m_mem[m_idx], m_cnt[m_idx], int'(cur_in[m_idx*W +: W]),
                                  int'(threshold), int'(beta), int'(refrac_len));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_mem[i] <= 0;
        m_cnt[i] <= 0;
      end
      m_spike <= '0;
      m_idx   <= 0;
      m_state <= 0;
      m_fd    <= 1'b0;
    end else begin
      m_state <= m_mem[sel];
      m_fd    <= en && (m_idx == N - 1);
      if (en) begin
        m_mem[m_idx]   <= m_nxt.mem;
        m_cnt[m_idx]   <= m_nxt.cnt;
        m_spike[m_idx] <= m_nxt.spk;
        m_idx          <= (m_idx + 1) % N;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("model_spike", int'(spike), int'(m_spike));
      check("model_state_out", int'(state_out), m_state);
      check("model_frame_done", int'(frame_done), int'(m_fd));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_spike", int'(spike), 0);
    check("rst_state_out", int'(state_out), 0);
    check("rst_frame_done", int'(frame_done), 0);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int spk_cnt;
    int fd_cnt;
    int last_fd;

    rst_n      = 1'b0;
    en         = 1'b0;
    cur_in     = '0;
    threshold  = 8'd128;
    beta       = 3'd3;
    refrac_len = 3'd0;
    sel        = 2'd0;
    repeat (2) @(negedge clk);
    check("init_spike", int'(spike), 0);
    check("init_state_out", int'(state_out), 0);
    rst_n = 1'b1;

    // Integration: 64, 120, spike with residual 41
    cur_in    = {8'd0, 8'd0, 8'd0, 8'd64};
    threshold = 8'd128;
    beta      = 3'd3;
    sel       = 2'd0;
    en        = 1'b1;
    cyc(2);
    check("int_mem_upd1", int'(state_out), 64);
    check("int_model_upd1", m_state, 64);
    cyc(4);
    check("int_mem_upd2", int'(state_out), 120);
    spk_cnt = 0;
    for (int i = 6; i <= 15; i++) begin
      cyc();
      if (spike[0]) spk_cnt++;
      if (i == 8) check("int_spike_upd3", int'(spike[0]), 1);
      if (i == 9) check("int_mem_upd3", int'(state_out), 41);
    end
    check("int_spike_width", spk_cnt, 4);
    cyc();

    // Mid-frame reset with nonzero membranes, then saturation on neuron 0
    do_reset();
    cur_in    = {8'd0, 8'd0, 8'd0, 8'd200};
    threshold = 8'd255;
    beta      = 3'd7;
    sel       = 2'd0;
    en        = 1'b1;
    cyc(2);
    check("sat_first_upd_n0", int'(state_out), 200);
    cyc(3);
    check("sat_spike", int'(spike[0]), 1);
    cyc();
    check("sat_residual", int'(state_out), 0);

    // Refractory
    do_reset();
    cur_in     = {8'd0, 8'd0, 8'd0, 8'd255};
    threshold  = 8'd100;
    beta       = 3'd0;
    refrac_len = 3'd2;
    sel        = 2'd0;
    en         = 1'b1;
    cyc();
    check("ref_spike_u1", int'(spike[0]), 1);
    cyc();
    check("ref_mem_u1", int'(state_out), 155);
    cyc(3);
`ifdef LIF_ARRAY_REFRAC_EN
    check("ref_spike_u2", int'(spike[0]), 0);
    cyc();
    check("ref_mem_u2", int'(state_out), 0);
    cyc(3);
    check("ref_spike_u3", int'(spike[0]), 0);
`else
    check("ref_spike_u2", int'(spike[0]), 1);
    cyc();
    check("ref_mem_u2", int'(state_out), 155);
    cyc(3);
    check("ref_spike_u3", int'(spike[0]), 1);
`endif
    cyc(4);
    check("ref_spike_u4", int'(spike[0]), 1);

    // Enable stall after neuron 1's update
    do_reset();
    cur_in     = {8'd40, 8'd30, 8'd20, 8'd10};
    threshold  = 8'd200;
    beta       = 3'd1;
    refrac_len = 3'd0;
    sel        = 2'd1;
    en         = 1'b1;
    cyc(2);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("stall_frame_done", int'(frame_done), 0);
      check("stall_mem1", int'(state_out), 20);
      check("stall_spike", int'(spike), 0);
    end
    en  = 1'b1;
    sel = 2'd2;
    cyc(2);
    check("resume_n2_mem", int'(state_out), 30);
    check("resume_frame_done", int'(frame_done), 1);

    // frame_done cadence with en held high
    fd_cnt  = 0;
    last_fd = -1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (frame_done) begin
        fd_cnt++;
        if (last_fd >= 0) check("fd_spacing", i - last_fd, 4);
        last_fd = i;
      end
    end
    check("fd_count", fd_cnt, 10);

    // Randomised mix against the model, en toggling and threshold 0 included
    for (int i = 0; i < 300; i++) begin
      en         = ($urandom_range(0, 3) != 0);
      cur_in     = {$urandom_range(0, 255), $urandom_range(0, 255)} & 32'hffff_ffff;
      cur_in     = $urandom();
      threshold  = 8'($urandom_range(0, 255));
      beta       = 3'($urandom_range(0, 7));
      refrac_len = 3'($urandom_range(0, 7));
      sel        = 2'($urandom_range(0, 3));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
